time_disp_scan: RTL and testbench

- Display-side reader of the wall-clock packed time word {hour, 4'h0, minute, 4'h0, second}, BCD fields, 32 bits.
- Drives an 8-digit multiplexed common-anode 7-segment display. Scans digits 7 to 0 with dead-time blanking.
- Latches a tear-free snapshot of the time word once per frame.
- Renders the two 4'h0 separator nibbles as blinking dashes driven by the 1 s tick.

---
 rtl/time_disp_scan.sv | 108 ++++++++++
 tb/tb_time_disp_scan.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/time_disp_scan.sv
// Multiplexed 8-digit common-anode 7-segment scanner for the packed BCD time word.
// Snapshots the time word once per frame so a scan never shows a half-updated time.
module time_disp_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2,
  parameter int LZ_BLANK  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] time_in,
  input  logic        tick_1s,
  input  logic        blank_en,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_sync
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic          phase_q, phase_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          fsync_q, fsync_d;

  logic          slot_end;
  logic          wrap;
  logic [3:0]    nib;

  function automatic logic [7:0] font7(input logic [3:0] n);
    logic [7:0] f;
    case (n)
      4'h0: f = 8'hC0;
      4'h1: f = 8'hF9;
      4'h2: f = 8'hA4;
      4'h3: f = 8'hB0;
      4'h4: f = 8'h99;
      4'h5: f = 8'h92;
      4'h6: f = 8'h82;
      4'h7: f = 8'hF8;
      4'h8: f = 8'h80;
      4'h9: f = 8'h90;
      4'hA: f = 8'h88;
      4'hB: f = 8'h83;
      4'hC: f = 8'hC6;
      4'hD: f = 8'hA1;
      4'hE: f = 8'h86;
      default: f = 8'h8E;
    endcase
    return f;
  endfunction

  always_comb begin
    slot_end = (cnt_q == CNT_LAST);
    wrap     = slot_end && (idx_q == 3'd0);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = slot_end ? idx_q - 3'd1 : idx_q;
    snap_d   = wrap ? time_in : snap_q;
    fsync_d  = wrap;
    phase_d  = phase_q ^ tick_1s;

    nib = snap_q[{idx_q, 2'b00} +: 4];

    // Digits 5 and 2 sit on the zero separator nibbles and show a blinking dash instead.
    if (idx_q == 3'd5 || idx_q == 3'd2) begin
      seg_d = phase_q ? 8'hBF : 8'hFF;
    end else if (LZ_BLANK != 0 && idx_q == 3'd7 && nib == 4'h0) begin
      seg_d = 8'hFF;
    end else begin
      seg_d = font7(nib);
    end

    if (cnt_q >= CNT_BLANK && !blank_en) begin
      an_d = ~(8'b1 << idx_q);
    end else begin
      an_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= 3'd7;
      snap_q  <= 32'h0;
      phase_q <= 1'b1;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      fsync_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fsync_q <= fsync_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_sync = fsync_q;

endmodule

// File: tb/tb_time_disp_scan.sv
// Randomized bench for time_disp_scan against a cycle-count arithmetic reference model.
// Two instances share stimulus: (4,1,LZ=1) and (4,2,LZ=0).
module tb_time_disp_scan;

  localparam int SD    = 4;
  localparam int FRAME = SD * 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] time_in;
  logic        tick_1s;
  logic        blank_en;
  logic [7:0]  an_a, seg_a, an_b, seg_b;
  logic        fs_a, fs_b;

  int n_vec = 0;
  int n_err = 0;

  int          n;
  logic [31:0] m_snap;
  bit          m_phase;
  logic [7:0]  e_an_a, e_seg_a, e_an_b, e_seg_b;
  logic        e_fs;
  logic [7:0]  font [16];
  logic [7:0]  lit_seg [8];
  logic [7:0]  lit_an [8];

  always #5 clk = ~clk;

  time_disp_scan #(.SCAN_DIV(SD), .BLANK_CYC(1), .LZ_BLANK(1)) dut_a (
    .clk(clk), .rst(rst), .time_in(time_in), .tick_1s(tick_1s), .blank_en(blank_en),
    .an(an_a), .seg(seg_a), .frame_sync(fs_a)
  );

  time_disp_scan #(.SCAN_DIV(SD), .BLANK_CYC(2), .LZ_BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .time_in(time_in), .tick_1s(tick_1s), .blank_en(blank_en),
    .an(an_b), .seg(seg_b), .frame_sync(fs_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int idx, input bit lz);
    logic [3:0] nib;
    nib = m_snap[4*idx +: 4];
    if (idx == 5 || idx == 2) return m_phase ? 8'hBF : 8'hFF;
    if (lz && idx == 7 && nib == 4'h0) return 8'hFF;
    return font[nib];
  endfunction

  function automatic logic [7:0] exp_an(input int cnt, input int idx, input int bc);
    if (cnt >= bc && !blank_en) return 8'hFF ^ (8'd1 << idx);
    return 8'hFF;
  endfunction

  function automatic int cur_cnt();
    return n % SD;
  endfunction

  function automatic int cur_idx();
    return 7 - ((n / SD) % 8);
  endfunction

  task automatic model_reset();
    n = 0; m_snap = 32'h0; m_phase = 1'b1;
    e_an_a = 8'hFF; e_seg_a = 8'hFF; e_an_b = 8'hFF; e_seg_b = 8'hFF; e_fs = 1'b0;
  endtask

  // Expected outputs after the coming edge, from the pre-edge position and current inputs.
  task automatic model_edge();
    int cnt, idx;
    if (!rst) begin
      model_reset();
    end else begin
      cnt = cur_cnt();
      idx = cur_idx();
      e_an_a  = exp_an(cnt, idx, 1);
      e_an_b  = exp_an(cnt, idx, 2);
      e_seg_a = exp_seg(idx, 1'b1);
      e_seg_b = exp_seg(idx, 1'b0);
      e_fs    = (cnt == SD - 1) && (idx == 0);
      if (e_fs) m_snap = time_in;
      if (tick_1s) m_phase = !m_phase;
      n++;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("an_a", an_a, e_an_a);
    chk("seg_a", seg_a, e_seg_a);
    chk("fs_a", {7'd0, fs_a}, {7'd0, e_fs});
    chk("an_b", an_b, e_an_b);
    chk("seg_b", seg_b, e_seg_b);
    chk("fs_b", {7'd0, fs_b}, {7'd0, e_fs});
  endtask

  function automatic logic [31:0] rand_time();
    logic [31:0] t;
    for (int i = 0; i < 8; i++) t[4*i +: 4] = ($urandom % 4 == 0) ? 4'h0 : 4'($urandom % 16);
    return t;
  endfunction

  initial begin
    int k, pulses;
    font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    lit_seg = '{8'hA4, 8'hB0, 8'hBF, 8'h92, 8'h90, 8'hBF, 8'hC0, 8'hF8};
    lit_an  = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    rst = 1'b0; time_in = 32'h23059007; tick_1s = 1'b0; blank_en = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_an", an_a, 8'hFF);
    chk("rst_seg", seg_a, 8'hFF);
    chk("rst_fs", {7'd0, fs_a}, 8'h00);
    for (int i = 0; i < 3; i++) step();

    // Two full frames with a fixed time word; frame 2 also checked against literal values.
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      k = n;
      step();
      if (fs_a) pulses++;
      if (k < FRAME) chk("pre_fs", {7'd0, fs_a}, {7'd0, k == FRAME - 1});
      if (k >= FRAME && k % SD == 0) chk("lit_gap", an_a, 8'hFF);
      if (k >= FRAME && k % SD == 1) begin
        chk("lit_seg", seg_a, lit_seg[(k - FRAME) / SD]);
        chk("lit_an", an_a, lit_an[(k - FRAME) / SD]);
      end
    end
    chk("fs_count", 8'(pulses), 8'd2);

    // Mid-frame time change at digit 4.
    for (int i = 0; i < FRAME && cur_idx() != 4; i++) step();
    time_in = 32'h11022033;
    for (int i = 0; i < 2 * FRAME; i++) step();

    // Separator blink, including a tick on the wrap edge.
    tick_1s = 1'b1; step(); tick_1s = 1'b0;
    for (int i = 0; i < 12; i++) step();
    tick_1s = 1'b1; step(); tick_1s = 1'b0;
    for (int i = 0; i < FRAME && !(cur_idx() == 0 && cur_cnt() == SD - 1); i++) step();
    tick_1s = 1'b1; time_in = 32'h09000000; step(); tick_1s = 1'b0;
    for (int i = 0; i < FRAME; i++) step();

    // Blanking window, then asynchronous reset mid-slot at digit 3.
    blank_en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    blank_en = 1'b0;
    for (int i = 0; i < FRAME && !(cur_idx() == 3 && cur_cnt() == 2); i++) step();
    #2 rst = 1'b0;
    #1;
    chk("arst_an", an_a, 8'hFF);
    chk("arst_seg", seg_a, 8'hFF);
    chk("arst_fs", {7'd0, fs_a}, 8'h00);
    model_reset();
    @(negedge clk);
    step();
    rst = 1'b1;
    for (int i = 0; i < FRAME + 4; i++) step();

    // Randomized soak.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 20 == 0) time_in = rand_time();
      tick_1s  = ($urandom % 10 == 0);
      if ($urandom % 16 == 0) blank_en = !blank_en;
      rst = ($urandom % 300 != 0);
      step();
    end
    rst = 1'b1; tick_1s = 1'b0; blank_en = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
